shell_launch_scheduler: RTL and testbench

//  Frame-rate scheduler sharing a fixed pool of shell slots among all tanks (player + enemies).

---
 rtl/battle_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/shell_launch_scheduler.sv | 92 +++++++++
 tb/tb_shell_launch_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// battle_pkg: shared battle constants, direction encoding and launch command record
package battle_pkg;
  typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_t;
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;
  localparam int NUM_TANKS_DEF = 4;
  localparam int NUM_SLOTS_DEF = 4;
  localparam int SLOT_W = $clog2(NUM_SLOTS_DEF);
  localparam int OWNER_W = $clog2(NUM_TANKS_DEF);
  typedef struct packed {
    logic [SLOT_W-1:0]  slot;
    logic [OWNER_W-1:0] owner;
    logic [9:0]         x;
    logic [9:0]         y;
    dir_t               dir;
  } launch_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr, wrapping around
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        idx = W'((int'(ptr) + k) % N);
        valid = 1'b1;
      end
    grant = {{(N-1){1'b0}}, valid} << idx;
  end
endmodule

// File: rtl/shell_launch_scheduler.sv
// shell_launch_scheduler: shares a pool of shell slots among tanks, one launch per frame
module shell_launch_scheduler
  import battle_pkg::*;
#(
  parameter int NUM_TANKS = NUM_TANKS_DEF,
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int MAX_PER_TANK = 1,
  parameter int COOLDOWN_FRAMES = 16
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic                         run,
  input  logic                         flush,
  input  logic [NUM_TANKS-1:0]         fire_req,
  input  logic [NUM_TANKS*10-1:0]      tank_x,
  input  logic [NUM_TANKS*10-1:0]      tank_y,
  input  logic [NUM_TANKS*2-1:0]       tank_dir,
  input  logic [NUM_SLOTS-1:0]         slot_done,
  output logic                         launch_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] launch_slot,
  output logic [$clog2(NUM_TANKS)-1:0] launch_owner,
  output logic [9:0]                   launch_x,
  output logic [9:0]                   launch_y,
  output logic [1:0]                   launch_dir,
  output logic [NUM_SLOTS-1:0]         slot_busy
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int OW = $clog2(NUM_TANKS);
  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam int IW = $clog2(NUM_SLOTS + 1);
  logic [OW-1:0] owner [NUM_SLOTS];
  logic [CD_W-1:0] cooldown [NUM_TANKS];
  logic [IW-1:0] inflight [NUM_TANKS];
  logic [NUM_TANKS-1:0] eligible, win_oh;
  logic [OW-1:0] rr_ptr, win;
  logic [SW-1:0] free_idx;
  logic win_ok, free_ok, grant;
  launch_cmd_t cmd;
  always_comb begin
    for (int t = 0; t < NUM_TANKS; t++) begin
      inflight[t] = '0;
      for (int s = 0; s < NUM_SLOTS; s++)
        inflight[t] = inflight[t] + IW'(slot_busy[s] && owner[s] == OW'(t));
      eligible[t] = fire_req[t] && cooldown[t] == '0 && inflight[t] < IW'(MAX_PER_TANK);
    end
  end
  always_comb begin
    free_idx = '0;
    free_ok = 1'b0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--)
      if (!slot_busy[s]) begin
        free_idx = SW'(s);
        free_ok = 1'b1;
      end
  end
  rr_arbiter #(.N(NUM_TANKS), .W(OW)) u_arb (
    .req(eligible), .ptr(rr_ptr), .grant(win_oh), .idx(win), .valid(win_ok)
  );
  assign grant = run && !flush && win_ok && free_ok;
  // Slot release uses the pre-edge busy vector, so a freed slot is only grantable next frame
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      launch_valid <= 1'b0;
      cmd <= '0;
      rr_ptr <= '0;
      slot_busy <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) owner[s] <= '0;
      for (int t = 0; t < NUM_TANKS; t++) cooldown[t] <= '0;
    end else begin
      launch_valid <= grant;
      if (grant) begin
        cmd <= '{slot: free_idx, owner: win, x: tank_x[win*10 +: 10], y: tank_y[win*10 +: 10],
                 dir: dir_t'(tank_dir[win*2 +: 2])};
        rr_ptr <= (win == OW'(NUM_TANKS - 1)) ? '0 : win + 1'b1;
      end
      for (int s = 0; s < NUM_SLOTS; s++)
        if (flush) slot_busy[s] <= 1'b0;
        else if (grant && free_idx == SW'(s)) begin
          slot_busy[s] <= 1'b1;
          owner[s] <= win;
        end else if (slot_done[s]) slot_busy[s] <= 1'b0;
      for (int t = 0; t < NUM_TANKS; t++)
        if (grant && win_oh[t]) cooldown[t] <= CD_W'(COOLDOWN_FRAMES);
        else if (run && cooldown[t] != '0) cooldown[t] <= cooldown[t] - 1'b1;
    end
  end
  assign launch_slot = cmd.slot;
  assign launch_owner = cmd.owner;
  assign launch_x = cmd.x;
  assign launch_y = cmd.y;
  assign launch_dir = cmd.dir;
endmodule

// File: tb/tb_shell_launch_scheduler.sv
// tb_shell_launch_scheduler: directed scenarios plus random traffic against a rule-level model
module tb_shell_launch_scheduler;
  logic frame_clk = 0, Reset = 1, run = 0, flush = 0;
  logic [3:0] fire_req = 0, slot_done = 0;
  logic [39:0] tank_x = 0, tank_y = 0;
  logic [7:0] tank_dir = 0;
  logic launch_valid;
  logic [1:0] launch_slot, launch_owner, launch_dir;
  logic [9:0] launch_x, launch_y;
  logic [3:0] slot_busy;
  int checks = 0, passes = 0, edges = 0, g_f = 0;
  bit m_busy[4];
  int m_own[4], m_cd[4], m_rr, m_slot, m_owner;
  bit m_lv;
  logic [9:0] m_x, m_y;
  logic [1:0] m_dir;

  shell_launch_scheduler dut (
    .frame_clk(frame_clk), .Reset(Reset), .run(run), .flush(flush), .fire_req(fire_req),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .slot_done(slot_done),
    .launch_valid(launch_valid), .launch_slot(launch_slot), .launch_owner(launch_owner),
    .launch_x(launch_x), .launch_y(launch_y), .launch_dir(launch_dir), .slot_busy(slot_busy)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [3:0] m_busy_vec();
    for (int s = 0; s < 4; s++) m_busy_vec[s] = m_busy[s];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0; m_own[i] = 0; m_cd[i] = 0;
    end
    m_rr = 0; m_lv = 0; m_slot = 0; m_owner = 0; m_x = 0; m_y = 0; m_dir = 0;
  endtask

  // Applies the scheduling rules to the current inputs, then advances one frame
  task automatic tick();
    int w, fs, n, t;
    bit g;
    w = -1; fs = -1;
    for (int k = 0; k < 4; k++) begin
      t = (m_rr + k) % 4;
      n = 0;
      for (int s = 0; s < 4; s++) if (m_busy[s] && m_own[s] == t) n++;
      if (w < 0 && fire_req[t] && m_cd[t] == 0 && n < 1) w = t;
    end
    for (int s = 0; s < 4; s++) if (fs < 0 && !m_busy[s]) fs = s;
    g = run && !flush && w >= 0 && fs >= 0;
    for (int i = 0; i < 4; i++)
      if (g && i == w) m_cd[i] = 16;
      else if (run && m_cd[i] > 0) m_cd[i]--;
    if (flush) for (int s = 0; s < 4; s++) m_busy[s] = 0;
    else begin
      for (int s = 0; s < 4; s++) if (slot_done[s]) m_busy[s] = 0;
      if (g) begin m_busy[fs] = 1; m_own[fs] = w; end
    end
    m_lv = g;
    if (g) begin
      m_slot = fs; m_owner = w; m_rr = (w + 1) % 4;
      m_x = tank_x[w*10 +: 10]; m_y = tank_y[w*10 +: 10]; m_dir = tank_dir[w*2 +: 2];
    end
    @(posedge frame_clk);
    #1;
    edges++;
  endtask

  task automatic settle();
    flush = 1; tick(); flush = 0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (launch_valid !== 0) $display("FAIL reset_valid got %b want 0", launch_valid); else passes++;
    checks++; if (slot_busy !== 0) $display("FAIL reset_busy got %b want 0000", slot_busy); else passes++;
    checks++; if ({launch_slot, launch_owner, launch_dir} !== 0) $display("FAIL reset_cmd got %b want 0", {launch_slot, launch_owner, launch_dir}); else passes++;
    checks++; if ({launch_x, launch_y} !== 0) $display("FAIL reset_xy got %h want 0", {launch_x, launch_y}); else passes++;
    @(posedge frame_clk); #1;
    Reset = 0;
    m_reset();
  endtask

  task automatic test_single_launch();
    tank_x[9:0] = 100; tank_y[9:0] = 200; tank_dir[1:0] = 2'b00;
    run = 1; fire_req = 4'b0001;
    tick(); g_f = edges;
    checks++; if (launch_valid !== 1) $display("FAIL single_valid got %b want 1", launch_valid); else passes++;
    checks++; if (launch_slot !== 0 || launch_owner !== 0) $display("FAIL single_slot_owner got %0d/%0d want 0/0", launch_slot, launch_owner); else passes++;
    checks++; if (launch_x !== 100 || launch_y !== 200 || launch_dir !== 0) $display("FAIL single_origin got %0d,%0d,%0d want 100,200,0", launch_x, launch_y, launch_dir); else passes++;
    checks++; if (slot_busy !== 4'b0001) $display("FAIL single_busy got %b want 0001", slot_busy); else passes++;
    fire_req = 0;
    tick();
    checks++; if (launch_valid !== 0) $display("FAIL single_pulse got %b want 0", launch_valid); else passes++;
  endtask

  task automatic test_cooldown_inflight();
    bit found = 0;
    fire_req = 4'b0001;
    repeat (3) begin
      tick();
      checks++; if (launch_valid !== 0) $display("FAIL inflight_block got %b want 0", launch_valid); else passes++;
    end
    slot_done = 4'b0001; tick(); slot_done = 0;
    checks++; if (slot_busy !== 0 || launch_valid !== 0) $display("FAIL done_release got %b/%b want 0000/0", slot_busy, launch_valid); else passes++;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      checks++; if (launch_valid !== m_lv) $display("FAIL cooldown_valid got %b want %b", launch_valid, m_lv); else passes++;
      found = launch_valid;
    end
    checks++; if (!found || edges != g_f + 17) $display("FAIL cooldown_relaunch got edge %0d want %0d", edges - g_f, 17); else passes++;
    checks++; if (launch_slot !== 0) $display("FAIL relaunch_slot got %0d want 0", launch_slot); else passes++;
    fire_req = 0;
  endtask

  task automatic test_round_robin();
    int exp_o, grants = 0, m_grants = 0;
    settle();
    fire_req = 4'b1111;
    exp_o = m_rr;
    for (int i = 0; i < 60; i++) begin
      slot_done = m_busy_vec();
      tick();
      if (m_lv) m_grants++;
      checks++; if (launch_valid !== m_lv) $display("FAIL rr_valid got %b want %b", launch_valid, m_lv); else passes++;
      if (launch_valid) begin
        grants++;
        checks++; if (launch_owner !== 2'(exp_o)) $display("FAIL rr_owner got %0d want %0d", launch_owner, exp_o); else passes++;
        exp_o = (exp_o + 1) % 4;
      end
    end
    checks++; if (grants != 16 || m_grants != 16) $display("FAIL rr_count got %0d want 16", grants); else passes++;
    fire_req = 0; slot_done = 0;
  endtask

  task automatic test_pool_full();
    settle();
    fire_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (launch_valid !== 1 || launch_slot !== 2'(k)) $display("FAIL fill_slot got %b/%0d want 1/%0d", launch_valid, launch_slot, k); else passes++;
    end
    checks++; if (slot_busy !== 4'b1111) $display("FAIL full_busy got %b want 1111", slot_busy); else passes++;
    repeat (20) begin
      tick();
      checks++; if (launch_valid !== 0) $display("FAIL full_wait got %b want 0", launch_valid); else passes++;
    end
    slot_done = 4'b0100; tick(); slot_done = 0;
    checks++; if (launch_valid !== 0 || slot_busy !== 4'b1011) $display("FAIL release_edge got %b/%b want 0/1011", launch_valid, slot_busy); else passes++;
    tick();
    checks++; if (launch_valid !== 1 || launch_slot !== 2) $display("FAIL release_next got %b/%0d want 1/2", launch_valid, launch_slot); else passes++;
    checks++; if (slot_busy !== 4'b1111) $display("FAIL refill_busy got %b want 1111", slot_busy); else passes++;
    fire_req = 0;
  endtask

  task automatic test_pause_flush();
    int e0;
    bit found = 0;
    settle();
    fire_req = 4'b0001; tick(); fire_req = 0;
    checks++; if (launch_valid !== 1) $display("FAIL pause_grant got %b want 1", launch_valid); else passes++;
    repeat (6) tick();
    run = 0; fire_req = 4'b1111; slot_done = 4'b0001;
    repeat (5) begin
      tick(); slot_done = 0;
      checks++; if (launch_valid !== 0) $display("FAIL pause_nolaunch got %b want 0", launch_valid); else passes++;
    end
    checks++; if (slot_busy !== 0) $display("FAIL pause_done got %b want 0000", slot_busy); else passes++;
    run = 1; fire_req = 4'b0001; e0 = edges;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = launch_valid;
    end
    checks++; if (!found || edges != e0 + 11) $display("FAIL pause_frozen got edge %0d want 11", edges - e0); else passes++;
    fire_req = 0; flush = 1; tick(); flush = 0;
    checks++; if (slot_busy !== 0 || launch_valid !== 0) $display("FAIL flush got %b/%b want 0000/0", slot_busy, launch_valid); else passes++;
  endtask

  task automatic test_async_reset();
    settle();
    fire_req = 4'b0111;
    repeat (3) tick();
    fire_req = 0;
    checks++; if (slot_busy !== 4'b0111) $display("FAIL prereset_busy got %b want 0111", slot_busy); else passes++;
    #2; Reset = 1; #1;
    checks++; if (slot_busy !== 0 || launch_valid !== 0) $display("FAIL async_reset got %b/%b want 0000/0", slot_busy, launch_valid); else passes++;
    m_reset();
    @(posedge frame_clk); #1;
    Reset = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run = ($urandom % 10) != 0;
      flush = ($urandom % 30) == 0;
      fire_req = 4'($urandom);
      slot_done = 4'($urandom) & 4'($urandom);
      for (int t = 0; t < 4; t++) begin
        tank_x[t*10 +: 10] = 10'($urandom_range(639));
        tank_y[t*10 +: 10] = 10'($urandom_range(479));
      end
      tank_dir = 8'($urandom);
      tick();
      checks++; if (launch_valid !== m_lv || slot_busy !== m_busy_vec()) $display("FAIL rand_state got %b/%b want %b/%b", launch_valid, slot_busy, m_lv, m_busy_vec()); else passes++;
      if (m_lv) begin
        checks++;
        if (launch_slot !== 2'(m_slot) || launch_owner !== 2'(m_owner) || launch_x !== m_x || launch_y !== m_y || launch_dir !== m_dir)
          $display("FAIL rand_cmd got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d", launch_slot, launch_owner, launch_x, launch_y, launch_dir, m_slot, m_owner, m_x, m_y, m_dir);
        else passes++;
      end
    end
    run = 1; flush = 0; fire_req = 0; slot_done = 0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_launch();
    test_cooldown_inflight();
    test_round_robin();
    test_pool_full();
    test_pause_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
